// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported unified memory between fetch and load/store with a per-cycle grant.
// Latency: grant edge E0, memory access E0..E1, registered response valid E1..E2; one access per cycle.
// Backpressure: requesters hold req until gnt; data wins ties unless fetch has waited STARVE_MAX grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int DATA_BASE  = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_func3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [2:0]        mem_func3,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_OFS   = ADDR_W'(DATA_BASE);
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0]        F3_WORD    = 3'b010;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        starve_cnt;
    logic              fetch_forced;
    logic              if_win;
    logic              dm_win;
    logic              store_ok;

    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic              d_we_q;
    logic [2:0]        d_func3_q;
    logic [DATA_W-1:0] d_wdata_q;

    logic              if_rvalid_q;
    logic              dm_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    // Data has priority; fetch is forced through once it has lost STARVE_MAX grants in a row.
    always_comb begin
        fetch_forced = if_req && dm_req && (starve_cnt == STARVE_LIM);
        dm_win       = dm_req && !fetch_forced;
        if_win       = if_req && (!dm_req || fetch_forced);
    end

    assign if_gnt = if_win && !rst;
    assign dm_gnt = dm_win && !rst;

    // Only byte, half and word stores are legal; anything else completes without writing.
    assign store_ok = !d_func3_q[2] && (d_func3_q[1:0] != 2'b11);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: the state names the access the memory sees next cycle
    always_comb begin
        state_nxt = IDLE;
        if (if_win) begin
            state_nxt = SERVE_I;
        end else if (dm_win) begin
            state_nxt = SERVE_D;
        end
    end

    // Output logic: memory-side strobes, all forced low while in reset
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_func3 = 3'b000;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    mem_addr  = i_addr_q;
                    mem_rd    = 1'b1;
                    mem_func3 = F3_WORD;
                end
                SERVE_D: begin
                    mem_addr  = d_addr_q + BASE_OFS;
                    mem_rd    = !d_we_q;
                    mem_wr    = d_we_q && store_ok;
                    mem_func3 = d_func3_q;
                    mem_wdata = d_wdata_q;
                end
                default: begin
                    mem_addr = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!if_req || if_win) begin
            starve_cnt <= 4'd0;
        end else if (dm_win && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_we_q    <= 1'b0;
            d_func3_q <= 3'b000;
            d_wdata_q <= '0;
        end else begin
            if (if_win) begin
                i_addr_q <= if_addr;
            end
            if (dm_win) begin
                d_addr_q  <= dm_addr;
                d_we_q    <= dm_we;
                d_func3_q <= dm_func3;
                d_wdata_q <= dm_wdata;
            end
        end
    end

    // Responses capture the combinational read at the edge ending the access; rdata holds until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= (state == SERVE_I);
            dm_rvalid_q <= (state == SERVE_D);
            if (state == SERVE_I) begin
                if_rdata_q <= mem_rdata;
            end
            if (state == SERVE_D) begin
                dm_rdata_q <= d_we_q ? '0 : mem_rdata;
            end
        end
    end

    assign if_rvalid = if_rvalid_q && !rst;
    assign dm_rvalid = dm_rvalid_q && !rst;
    assign if_rdata  = rst ? '0 : if_rdata_q;
    assign dm_rdata  = rst ? '0 : dm_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(if_gnt && dm_gnt));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-array memory, per-cycle reference model and literal checks.
module tb_mem_port_arbiter;

    localparam int DATA_BASE  = 128;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_func3;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_func3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(32), .DATA_BASE(DATA_BASE), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_func3(dm_func3), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_func3(mem_func3),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Memory the DUT drives: combinational read, write at the rising edge.
    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_rd)
            mem_rdata = ext({mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                             mem[mem_addr + 8'd1], mem[mem_addr]}, mem_func3);
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem_ready <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3 != 3'b000) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            if (mem_func3 == 3'b010) begin
                mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Reference model: which access is in flight, and what each requester should see next.
    logic [7:0]  ref_mem [256];
    int          waited;
    int          cur_kind;     // 0 none, 1 fetch, 2 data
    logic [7:0]  cur_addr;
    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wd;
    logic        exp_if_rv, exp_dm_rv;
    logic [31:0] exp_if_rd, exp_dm_rd;
    logic        e_ig, e_dg, e_rd, e_wr;
    logic [2:0]  e_f3;
    int          ea;
    int          nbytes;
    logic [31:0] word;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
        waited = 0; cur_kind = 0; cur_addr = 0; cur_we = 0; cur_f3 = 0; cur_wd = 0;
        exp_if_rv = 0; exp_dm_rv = 0; exp_if_rd = 0; exp_dm_rd = 0;
        forever begin
            @(negedge clk);
            e_ig = 0; e_dg = 0;
            if (!rst) begin
                if (if_req && dm_req) begin
                    if (waited == STARVE_MAX) e_ig = 1; else e_dg = 1;
                end else begin
                    e_ig = if_req;
                    e_dg = dm_req;
                end
            end
            ea = 0; e_rd = 0; e_wr = 0; e_f3 = 0;
            if (!rst && cur_kind == 1) begin
                ea = int'(cur_addr); e_rd = 1; e_f3 = 3'b010;
            end else if (!rst && cur_kind == 2) begin
                ea = (int'(cur_addr) + DATA_BASE) % 256;
                e_rd = !cur_we; e_wr = cur_we && (cur_f3 <= 3'b010); e_f3 = cur_f3;
            end
            chk("if_gnt", 32'(if_gnt), 32'(e_ig));
            chk("dm_gnt", 32'(dm_gnt), 32'(e_dg));
            chk("mem_addr", 32'(mem_addr), 32'(ea));
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("mem_func3", 32'(mem_func3), 32'(e_f3));
            if (!rst && cur_kind == 2) chk("mem_wdata", mem_wdata, cur_wd);
            chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv && !rst));
            chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_rv && !rst));
            chk("if_rdata", if_rdata, rst ? 32'd0 : exp_if_rd);
            chk("dm_rdata", dm_rdata, rst ? 32'd0 : exp_dm_rd);

            if (rst) begin
                waited = 0; cur_kind = 0;
                exp_if_rv = 0; exp_dm_rv = 0; exp_if_rd = 0; exp_dm_rd = 0;
            end else begin
                word = {ref_mem[(ea + 3) % 256], ref_mem[(ea + 2) % 256],
                        ref_mem[(ea + 1) % 256], ref_mem[ea]};
                exp_if_rv = (cur_kind == 1);
                exp_dm_rv = (cur_kind == 2);
                if (cur_kind == 1) exp_if_rd = word;
                if (cur_kind == 2) begin
                    exp_dm_rd = cur_we ? 32'd0 : ext(word, cur_f3);
                    if (e_wr) begin
                        nbytes = (cur_f3 == 3'b000) ? 1 : (cur_f3 == 3'b001) ? 2 : 4;
                        for (int k = 0; k < nbytes; k++)
                            ref_mem[(ea + k) % 256] = cur_wd[8*k +: 8];
                    end
                end
                if (if_req && e_dg) begin
                    if (waited < STARVE_MAX) waited++;
                end else begin
                    waited = 0;
                end
                cur_kind = e_ig ? 1 : (e_dg ? 2 : 0);
                if (e_ig) cur_addr = if_addr;
                if (e_dg) begin
                    cur_addr = dm_addr; cur_we = dm_we; cur_f3 = dm_func3; cur_wd = dm_wdata;
                end
            end
        end
    end

    // Directed stimulus with literal expectations
    logic [7:0]  s_addr;
    logic        s_rd, s_wr, s_rv;
    logic [31:0] s_rdata;
    logic [11:0] pat;
    int          n_dm;
    int          bad;

    task automatic dm_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd);
        int n;
        dm_req = 1; dm_we = we; dm_func3 = f3; dm_addr = a; dm_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!dm_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("dm_gnt_wait", 32'(dm_gnt), 32'd1);
        @(posedge clk); #1;
        dm_req = 0;
        @(negedge clk);
        s_addr = mem_addr; s_rd = mem_rd; s_wr = mem_wr;
        @(posedge clk); #1;
        @(negedge clk);
        s_rv = dm_rvalid; s_rdata = dm_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_func3 = 0; dm_addr = 0; dm_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        if_req = 1; if_addr = 8'd4;
        @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Back-to-back fetches
        @(negedge clk);
        chk("fetch4_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk); #1;
        if_addr = 8'd8;
        @(negedge clk);
        chk("fetch8_gnt", 32'(if_gnt), 32'd1);
        chk("fetch4_mem_addr", 32'(mem_addr), 32'd4);
        @(posedge clk); #1;
        if_req = 0;
        @(negedge clk);
        chk("fetch4_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch4_rdata", if_rdata, 32'h07060504);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch8_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch8_rdata", if_rdata, 32'h0B0A0908);
        @(posedge clk); #1;

        dm_op(1'b1, 3'b010, 8'd0, 32'd17);
        chk("sw_mem_addr", 32'(s_addr), 32'd128);
        chk("sw_mem_wr", 32'(s_wr), 32'd1);
        chk("sw_rdata", s_rdata, 32'd0);
        dm_op(1'b0, 3'b010, 8'd0, 32'd0);
        chk("lw_mem_addr", 32'(s_addr), 32'd128);
        chk("lw_rvalid", 32'(s_rv), 32'd1);
        chk("lw_rdata", s_rdata, 32'd17);
        dm_op(1'b0, 3'b010, 8'd200, 32'd0);
        chk("wrap_mem_addr", 32'(s_addr), 32'd72);
        chk("wrap_rdata", s_rdata, 32'h4B4A4948);
        dm_op(1'b1, 3'b000, 8'd1, 32'h1FF);
        chk("sb_mem129", 32'(mem[129]), 32'hFF);
        chk("sb_mem130", 32'(mem[130]), 32'h00);
        dm_op(1'b0, 3'b100, 8'd1, 32'd0);
        chk("lbu_rdata", s_rdata, 32'h000000FF);
        dm_op(1'b0, 3'b000, 8'd1, 32'd0);
        chk("lb_rdata", s_rdata, 32'hFFFFFFFF);
        dm_op(1'b1, 3'b011, 8'd20, 32'h12345678);
        chk("badst_mem_wr", 32'(s_wr), 32'd0);
        chk("badst_rvalid", 32'(s_rv), 32'd1);
        chk("badst_mem148", 32'(mem[148]), 32'h94);
        dm_op(1'b0, 3'b011, 8'd0, 32'd0);
        chk("badld_rvalid", 32'(s_rv), 32'd1);
        chk("badld_rdata", s_rdata, 32'd0);

        // Both requesters held: fetch must get every fifth grant
        if_req = 1; if_addr = 8'd12;
        dm_req = 1; dm_we = 0; dm_func3 = 3'b010; dm_addr = 8'd4;
        pat = '0; n_dm = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = if_gnt;
            if (dm_gnt) n_dm++;
        end
        chk("arb_pattern", 32'(pat), 32'h210);
        chk("arb_dm_count", 32'(n_dm), 32'd10);
        @(posedge clk); #1;
        if_req = 0; dm_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset lands on the serve cycle of a store
        dm_req = 1; dm_we = 1; dm_func3 = 3'b010; dm_addr = 8'd8; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstsw_gnt", 32'(dm_gnt), 32'd1);
        @(posedge clk); #1;
        dm_req = 0; rst = 1;
        @(negedge clk);
        chk("rstsw_mem_wr", 32'(mem_wr), 32'd0);
        chk("rstsw_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstsw_rvalid", 32'(dm_rvalid), 32'd0);
        chk("rstsw_rdata", dm_rdata, 32'd0);
        @(posedge clk); #1;
        chk("rstsw_mem136", 32'(mem[136]), 32'h88);
        repeat (2) @(posedge clk);
        #1;

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
